qeciphy_gt_status_monitor: RTL and testbench

QECIPHY_GT_STATUS_MONITOR -- requirements
Module: qeciphy_gt_status_monitor

---
 rtl/qeciphy_gt_status_monitor.sv | 139 +++++++++++++
 tb/tb_qeciphy_gt_status_monitor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_gt_status_monitor.sv
// GT status qualifier and link-loss monitor: debounces the three GT status inputs, arms once the
// link is up, and on any loss raises a fixed-length re-reset request. Optional fault counter is
// built only when QECIPHY_GT_STATUS_FAULT_CNT_EN is defined.
module qeciphy_gt_status_monitor #(
  parameter int unsigned STABLE_CYCLES  = 64,
  parameter int unsigned HOLDOFF_CYCLES = 256
) (
  input  logic       axis_clk_i,
  input  logic       axis_rst_i,
  input  logic       gt_power_good_i,
  input  logic       gt_tx_rst_done_i,
  input  logic       gt_rx_rst_done_i,
  input  logic       rst_done_i,
  input  logic       clear_fault_i,
  output logic       gt_power_good_o,
  output logic       gt_tx_rst_done_o,
  output logic       gt_rx_rst_done_o,
  output logic       link_armed_o,
  output logic       rerst_req_o,
  output logic       fault_o,
  output logic [7:0] fault_cnt_o
);

  localparam int unsigned QW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [QW-1:0] QMax  = QW'(STABLE_CYCLES);
  localparam logic [HW-1:0] HLast = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [3:0] {
    StWait      = 4'b0001,
    StArmed     = 4'b0010,
    StFaultHold = 4'b0100,
    StRecover   = 4'b1000
  } state_e;

  logic [2:0]    status_raw;
  logic [QW-1:0] qual_cnt_q [3];
  logic [2:0]    qual_q;

  assign status_raw = {gt_rx_rst_done_i, gt_tx_rst_done_i, gt_power_good_i};

  // Deassertion is unfiltered: a low sample clears both counter and output on the same edge.
  always_ff @(posedge axis_clk_i) begin
    if (axis_rst_i) begin
      for (int i = 0; i < 3; i++) begin
        qual_cnt_q[i] <= '0;
      end
      qual_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!status_raw[i]) begin
          qual_cnt_q[i] <= '0;
          qual_q[i]     <= 1'b0;
        end else begin
          if (qual_cnt_q[i] != QMax) begin
            qual_cnt_q[i] <= qual_cnt_q[i] + QW'(1);
          end
          qual_q[i] <= (qual_cnt_q[i] == QMax);
        end
      end
    end
  end

  assign gt_power_good_o  = qual_q[0];
  assign gt_tx_rst_done_o = qual_q[1];
  assign gt_rx_rst_done_o = qual_q[2];

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          all_ok;
  logic          fault_event;

  assign all_ok = (&qual_q) & rst_done_i;

  always_comb begin
    state_d     = StWait;
    fault_event = 1'b0;
    hold_d      = '0;
    unique case (state_q)
      StWait:  state_d = all_ok ? StArmed : StWait;
      StArmed: begin
        if (all_ok) begin
          state_d = StArmed;
        end else begin
          state_d     = StFaultHold;
          fault_event = 1'b1;
        end
      end
      StFaultHold: begin
        hold_d  = hold_q + HW'(1);
        state_d = (hold_q == HLast) ? StRecover : StFaultHold;
      end
      // Wait for the reset controller to actually restart before re-arming.
      StRecover: state_d = rst_done_i ? StRecover : StWait;
      default:   state_d = StWait;
    endcase
  end

  always_ff @(posedge axis_clk_i) begin
    if (axis_rst_i) begin
      state_q <= StWait;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign link_armed_o = (state_q == StArmed);
  assign rerst_req_o  = (state_q == StFaultHold);

  // A new fault takes priority over a coincident clear.
  always_ff @(posedge axis_clk_i) begin
    if (axis_rst_i) begin
      fault_o <= 1'b0;
    end else if (fault_event) begin
      fault_o <= 1'b1;
    end else if (clear_fault_i) begin
      fault_o <= 1'b0;
    end
  end

`ifdef QECIPHY_GT_STATUS_FAULT_CNT_EN
  logic [7:0] fault_cnt_q;

  always_ff @(posedge axis_clk_i) begin
    if (axis_rst_i) begin
      fault_cnt_q <= 8'd0;
    end else if (fault_event && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign fault_cnt_o = fault_cnt_q;
`else
  assign fault_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_qeciphy_gt_status_monitor.sv
// Bench for qeciphy_gt_status_monitor: directed checks on a default-size instance and
// randomized checks of a small instance against a run-length/countdown reference model.
module tb_qeciphy_gt_status_monitor;

  localparam int unsigned SS = 3;
  localparam int unsigned SH = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-size instance
  logic       m_rst, m_pg, m_tx, m_rx, m_rdone, m_clr;
  logic       m_pg_o, m_tx_o, m_rx_o, m_link_o, m_rerst_o, m_fault_o;
  logic [7:0] m_cnt_o;

  qeciphy_gt_status_monitor #(
    .STABLE_CYCLES (64),
    .HOLDOFF_CYCLES(256)
  ) u_dut_main (
    .axis_clk_i      (clk),
    .axis_rst_i      (m_rst),
    .gt_power_good_i (m_pg),
    .gt_tx_rst_done_i(m_tx),
    .gt_rx_rst_done_i(m_rx),
    .rst_done_i      (m_rdone),
    .clear_fault_i   (m_clr),
    .gt_power_good_o (m_pg_o),
    .gt_tx_rst_done_o(m_tx_o),
    .gt_rx_rst_done_o(m_rx_o),
    .link_armed_o    (m_link_o),
    .rerst_req_o     (m_rerst_o),
    .fault_o         (m_fault_o),
    .fault_cnt_o     (m_cnt_o)
  );

  // Small instance for model-checked random runs
  logic       s_rst, s_pg, s_tx, s_rx, s_rdone, s_clr;
  logic       s_pg_o, s_tx_o, s_rx_o, s_link_o, s_rerst_o, s_fault_o;
  logic [7:0] s_cnt_o;

  qeciphy_gt_status_monitor #(
    .STABLE_CYCLES (SS),
    .HOLDOFF_CYCLES(SH)
  ) u_dut_small (
    .axis_clk_i      (clk),
    .axis_rst_i      (s_rst),
    .gt_power_good_i (s_pg),
    .gt_tx_rst_done_i(s_tx),
    .gt_rx_rst_done_i(s_rx),
    .rst_done_i      (s_rdone),
    .clear_fault_i   (s_clr),
    .gt_power_good_o (s_pg_o),
    .gt_tx_rst_done_o(s_tx_o),
    .gt_rx_rst_done_o(s_rx_o),
    .link_armed_o    (s_link_o),
    .rerst_req_o     (s_rerst_o),
    .fault_o         (s_fault_o),
    .fault_cnt_o     (s_cnt_o)
  );

  // Reference model: consecutive-high run lengths plus armed/holdoff/recover bookkeeping
  int run_pg, run_tx, run_rx;
  bit r_armed, r_recover, r_fault;
  int r_hold, r_cnt;

  function automatic int exp_cnt(input int n);
`ifdef QECIPHY_GT_STATUS_FAULT_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int next_run(input logic in, input int run);
    return in ? ((run < 1000) ? run + 1 : run) : 0;
  endfunction

  task automatic model_edge();
    bit qa;
    bit fev;
    fev = 1'b0;
    qa  = (run_pg > SS) && (run_tx > SS) && (run_rx > SS);
    if (s_rst) begin
      run_pg = 0; run_tx = 0; run_rx = 0;
      r_armed = 0; r_recover = 0; r_fault = 0; r_hold = 0; r_cnt = 0;
    end else begin
      if (r_hold > 0) begin
        r_hold--;
        if (r_hold == 0) r_recover = 1;
      end else if (r_recover) begin
        if (!s_rdone) r_recover = 0;
      end else if (r_armed) begin
        if (!(qa && s_rdone)) begin
          r_armed = 0;
          r_hold  = SH;
          fev     = 1'b1;
        end
      end else if (qa && s_rdone) begin
        r_armed = 1;
      end
      if (fev) begin
        r_fault = 1;
        if (r_cnt < 255) r_cnt++;
      end else if (s_clr) begin
        r_fault = 0;
      end
      run_pg = next_run(s_pg, run_pg);
      run_tx = next_run(s_tx, run_tx);
      run_rx = next_run(s_rx, run_rx);
    end
  endtask

  task automatic mstep();
    @(posedge clk);
    #1;
  endtask

  task automatic sstep();
    @(posedge clk);
    model_edge();
    #1;
    check("s_pg_o", 32'(s_pg_o), 32'(run_pg > SS));
    check("s_tx_o", 32'(s_tx_o), 32'(run_tx > SS));
    check("s_rx_o", 32'(s_rx_o), 32'(run_rx > SS));
    check("s_link_armed", 32'(s_link_o), 32'(r_armed));
    check("s_rerst_req", 32'(s_rerst_o), 32'(r_hold > 0));
    check("s_fault", 32'(s_fault_o), 32'(r_fault));
    check("s_fault_cnt", 32'(s_cnt_o), 32'(exp_cnt(r_cnt)));
  endtask

  initial begin
    int  n;
    bit  flag;
    m_rst = 1; m_pg = 0; m_tx = 0; m_rx = 0; m_rdone = 0; m_clr = 0;
    s_rst = 1; s_pg = 0; s_tx = 0; s_rx = 0; s_rdone = 0; s_clr = 0;

    // Reset state
    repeat (3) mstep();
    check("rst_pg_o", 32'(m_pg_o), 0);
    check("rst_link", 32'(m_link_o), 0);
    check("rst_rerst", 32'(m_rerst_o), 0);
    check("rst_fault", 32'(m_fault_o), 0);
    check("rst_cnt", 32'(m_cnt_o), 0);
    m_rst = 0;

    // Power-good qualification latency
    m_pg = 1;
    n = 0;
    do begin mstep(); n++; end while (!m_pg_o && n < 200);
    check("pg_rise_latency", n, 65);
    check("pg_tx_o_low", 32'(m_tx_o), 0);
    check("pg_rx_o_low", 32'(m_rx_o), 0);
    check("pg_link_low", 32'(m_link_o), 0);
    check("pg_rerst_low", 32'(m_rerst_o), 0);

    // 63-cycle glitch must not qualify
    m_tx = 1;
    flag = 0;
    repeat (63) begin mstep(); if (m_tx_o) flag = 1; end
    check("tx_glitch_63", 32'(flag), 0);
    m_tx = 0;
    mstep();
    check("tx_low_gap", 32'(m_tx_o), 0);
    m_tx = 1;
    n = 0;
    do begin mstep(); n++; end while (!m_tx_o && n < 200);
    check("tx_rise_latency", n, 65);

    m_rx = 1;
    n = 0;
    do begin mstep(); n++; end while (!m_rx_o && n < 200);
    check("rx_rise_latency", n, 65);
    check("no_arm_without_rst_done", 32'(m_link_o), 0);

    m_rdone = 1;
    mstep();
    check("armed", 32'(m_link_o), 1);

    // One-cycle rx drop while armed
    m_rx = 0;
    mstep();
    check("rx_o_drop", 32'(m_rx_o), 0);
    check("rerst_not_yet", 32'(m_rerst_o), 0);
    m_rx = 1;
    mstep();
    check("fault_set", 32'(m_fault_o), 1);
    check("link_drop", 32'(m_link_o), 0);
    n = 0;
    while (m_rerst_o && n < 1000) begin n++; mstep(); end
    check("holdoff_len", n, 256);
    check("cnt_after_1", 32'(m_cnt_o), 32'(exp_cnt(1)));

    // Recover holds while rst_done_i stays high
    flag = 0;
    repeat (20) begin mstep(); if (m_link_o || m_rerst_o) flag = 1; end
    check("recover_hold", 32'(flag), 0);
    m_rdone = 0;
    mstep();
    check("recover_to_wait", 32'(m_link_o), 0);
    m_rdone = 1;
    mstep();
    check("rearm", 32'(m_link_o), 1);

    // Clear coincident with a new fault: set wins
    m_rdone = 0;
    m_clr = 1;
    mstep();
    m_clr = 0;
    m_rdone = 1;
    check("set_wins_fault", 32'(m_fault_o), 1);
    check("set_wins_rerst", 32'(m_rerst_o), 1);
    check("cnt_after_2", 32'(m_cnt_o), 32'(exp_cnt(2)));
    repeat (2) mstep();
    m_clr = 1;
    mstep();
    m_clr = 0;
    check("clear_in_hold", 32'(m_fault_o), 0);
    repeat (7) mstep();
    check("still_hold", 32'(m_rerst_o), 1);

    // Reset in the middle of the holdoff
    m_rst = 1;
    mstep();
    check("midhold_rst_rerst", 32'(m_rerst_o), 0);
    check("midhold_rst_fault", 32'(m_fault_o), 0);
    check("midhold_rst_cnt", 32'(m_cnt_o), 0);
    check("midhold_rst_pg", 32'(m_pg_o), 0);
    m_rst = 0;

    // Randomized run on the small instance
    s_rst = 1;
    sstep();
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_pg    = ($urandom_range(0, 11) != 0);
      s_tx    = ($urandom_range(0, 11) != 0);
      s_rx    = ($urandom_range(0, 11) != 0);
      s_rdone = ($urandom_range(0, 9) != 0);
      s_clr   = ($urandom_range(0, 7) == 0);
      sstep();
    end

    // Repeated faults to saturate the counter, with clears on and off the fault edge
    s_rst = 1;
    sstep();
    s_rst = 0; s_pg = 1; s_tx = 1; s_rx = 1; s_rdone = 1; s_clr = 0;
    repeat (6) sstep();
    for (int p = 0; p < 310; p++) begin
      for (int ph = 0; ph < 10; ph++) begin
        s_rdone = !(ph == 0 || ph == 7);
        s_clr   = (ph == 0 && (p % 3) == 0) || (ph == 3 && (p % 3) == 1);
        sstep();
      end
    end
    check("cnt_saturated", 32'(s_cnt_o), 32'(exp_cnt(255)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
